input_debouncer: RTL and testbench
==================================

Name: input_debouncer

Overview:
- Upstream conditioning stage for the level-trigger sequence FSM.
- Takes an asynchronous, bouncy raw input, synchronises it into the `clk` domain, and filters it so only stable levels pass.
- Drives a clean level (`clean_out`, wired to the FSM's `X`) plus single-cycle edge pulses for other consumers.

Parameters:
- SYNC_STAGES, 2, number of flops in the synchroniser chain; legal range 2..4.
- DEBOUNCE_CYCLES, 4, consecutive synchronised samples at the new level required to accept a change; legal range 2..65535; elaboration error outside range.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- raw_in  input  1  unsynchronised, possibly bouncing input.
- clean_out  output  1  debounced level; feeds downstream X.
- rise_pulse  output  1  one-cycle pulse when clean_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when clean_out goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Interface: one clock, `clk`. Reset `reset` is asynchronous and active-high. All flops reset on posedge reset.
- Reset values:
  - synchroniser flops all 0
  - state STABLE_LOW
  - counter 0
  - clean_out 0, rise_pulse 0, fall_pulse 0, busy 0
- Synchroniser:
  - raw_in enters a SYNC_STAGES-deep flop chain.
  - s = last stage. No other logic reads raw_in.
- Counter: cnt, width $clog2(DEBOUNCE_CYCLES+1), unsigned. It never wraps, because it is cleared or stops before reaching DEBOUNCE_CYCLES.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. All transitions happen on the clk edge.
  - STABLE_LOW:
    - s=1 -> WAIT_HIGH, cnt<=1.
    - else stay, cnt<=0.
  - WAIT_HIGH:
    - s=0 -> STABLE_LOW, cnt<=0 (glitch rejected, no pulse).
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HIGH, cnt<=0, clean_out<=1, rise_pulse<=1.
    - else cnt<=cnt+1.
  - STABLE_HIGH: mirror of STABLE_LOW, with s=0 -> WAIT_LOW.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - s=1 aborts to STABLE_HIGH.
    - Qualification -> STABLE_LOW, clean_out<=0, fall_pulse<=1.
  - Illegal state encoding -> STABLE_LOW, cnt<=0; outputs not updated that cycle.
- Output timing:
  - clean_out, rise_pulse and fall_pulse are registered.
  - rise_pulse and fall_pulse are high for exactly one cycle, the same cycle clean_out first shows the new level. They are never both high.
  - busy is combinational from state: 1 in WAIT_HIGH or WAIT_LOW.
- Latency: a clean raw_in step that holds steady appears on clean_out exactly SYNC_STAGES + DEBOUNCE_CYCLES rising edges after it is first captured by sync stage 1.
- Glitch rejection: any excursion shorter than DEBOUNCE_CYCLES synchronised samples produces no change on clean_out and no pulse.
- Bounce during qualification restarts the qualification from scratch on the next edge toward the new level. Qualification is not cumulative.
- Reset mid-qualification:
  - Immediate return to reset values.
  - No pulse is emitted, even if the qualifying cycle coincides with reset assertion.
- After reset deassertion, if raw_in is already 1, the block qualifies it as a normal rise, so downstream sees one rise_pulse.

Decomposition:
- Shared package `debounce_pkg`:
  - typedef enum logic [1:0] deb_state_t (STABLE_LOW=2'b00, WAIT_HIGH=2'b01, STABLE_HIGH=2'b10, WAIT_LOW=2'b11)
  - localparam bounds DEB_MIN_CYCLES=2, DEB_MAX_CYCLES=65535
- One sub-module: `sync_chain` (parameter STAGES, ports clk, reset, d, q), reused by other input stages.

Test Plan:
- Reset then hold raw_in=0 for 20 cycles -> clean_out=0, no pulses, busy=0 throughout.
- Defaults (SYNC=2, DEB=4); raw_in 0->1 and held -> clean_out rises on edge 6 after capture; rise_pulse high exactly that one cycle; busy high for the 3 preceding cycles.
- raw_in 1-cycle and 3-cycle high glitches from STABLE_LOW -> clean_out stays 0, no rise_pulse, busy returns to 0.
- Bounce pattern 1,1,0,1,1,1,1 after a stable low -> qualification restarts at the 0; clean_out rises 4 samples after the final run begins; single rise_pulse.
- From STABLE_HIGH, raw_in held at 0 -> fall_pulse one cycle, clean_out=0 after latency 6. Downstream FSM check: 0 then 1 on clean_out makes the FSM output go high once.
- reset asserted while cnt==3 in WAIT_HIGH -> immediate clean_out=0, no pulse. raw_in held 1 through deassertion -> full 6-edge requalification, then one rise_pulse.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and parameter bounds for input conditioning stages
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } deb_state_t;

    localparam int DEB_MIN_CYCLES  = 2;
    localparam int DEB_MAX_CYCLES  = 65535;
    localparam int SYNC_MIN_STAGES = 2;
    localparam int SYNC_MAX_STAGES = 4;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser bringing an asynchronous level into the clk domain
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift the raw level one stage deeper each cycle
    always_comb sync_d = {sync_q[STAGES-2:0], d};

    // chain flops, cleared on reset so the filter starts from a known low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronise and filter a bouncy input into a clean level plus edge pulses
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < DEB_MIN_CYCLES || DEBOUNCE_CYCLES > DEB_MAX_CYCLES) begin : g_bad_deb
        $error("input_debouncer: DEBOUNCE_CYCLES %0d out of range", DEBOUNCE_CYCLES);
    end
    if (SYNC_STAGES < SYNC_MIN_STAGES || SYNC_STAGES > SYNC_MAX_STAGES) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES %0d out of range", SYNC_STAGES);
    end

    logic          s;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    // qualify a level change only after DEBOUNCE_CYCLES consecutive matching samples
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                state_d = s ? WAIT_HIGH : STABLE_LOW;
                cnt_d   = s ? CW'(1) : '0;
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            STABLE_HIGH: begin
                state_d = s ? STABLE_HIGH : WAIT_LOW;
                cnt_d   = s ? '0 : CW'(1);
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // state, counter and registered outputs; reset wins over any qualifying edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: scoreboard bench comparing the debouncer against a run-length reference
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_in = 1'b0;
    logic clean_out, rise_pulse, fall_pulse, busy;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0]      sb_q[$];
    logic [SYNC-1:0] sm = '0;
    logic            clean_m = 1'b0;
    int              run_m = 0;
    int              rise_n = 0;
    int              fall_n = 0;
    int              busy_n = 0;
    int              n;
    int              pat[7] = '{1, 1, 0, 1, 1, 1, 1};

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sm      = '0;
        clean_m = 1'b0;
        run_m   = 0;
    endtask

    task automatic clear_counts();
        rise_n = 0;
        fall_n = 0;
        busy_n = 0;
    endtask

    task automatic step(input logic v);
        logic s_old, rm, fm;
        logic [3:0] exp;
        raw_in = v;
        @(posedge clk);
        rm = 1'b0;
        fm = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            s_old = sm[SYNC-1];
            sm    = {sm[SYNC-2:0], raw_in};
            run_m = (s_old != clean_m) ? run_m + 1 : 0;
            if (run_m == DEB) begin
                clean_m = !clean_m;
                rm      = clean_m;
                fm      = !clean_m;
                run_m   = 0;
            end
        end
        sb_q.push_back({clean_m, rm, fm, run_m != 0});
        @(negedge clk);
        exp = sb_q.pop_front();
        chk("sb", {clean_out, rise_pulse, fall_pulse, busy}, exp);
        chk("pulse_excl", rise_pulse & fall_pulse, 0);
        rise_n += int'(rise_pulse);
        fall_n += int'(fall_pulse);
        busy_n += int'(busy);
    endtask

    initial begin
        #1;
        chk("rst_out", {clean_out, rise_pulse, fall_pulse, busy}, 4'b0000);
        step(0);
        step(0);
        reset = 1'b0;

        clear_counts();
        repeat (20) step(0);
        chk("idle_clean", clean_out, 0);
        chk("idle_pulses", rise_n + fall_n, 0);
        chk("idle_busy", busy_n, 0);

        clear_counts();
        for (n = 1; n <= 20; n++) begin
            step(1);
            if (clean_out) break;
        end
        chk("rise_lat", n, 6);
        chk("rise_busy", busy_n, 3);
        chk("rise_cnt", rise_n, 1);
        repeat (4) step(1);
        chk("rise_once", rise_n, 1);

        clear_counts();
        for (n = 1; n <= 20; n++) begin
            step(0);
            if (!clean_out) break;
        end
        chk("fall_lat", n, 6);
        chk("fall_busy", busy_n, 3);
        chk("fall_cnt", fall_n, 1);
        chk("fall_norise", rise_n, 0);

        clear_counts();
        repeat (4) step(0);
        step(1);
        repeat (8) step(0);
        repeat (3) step(1);
        repeat (8) step(0);
        chk("glitch_clean", clean_out, 0);
        chk("glitch_rise", rise_n, 0);
        chk("glitch_busy", busy, 0);

        clear_counts();
        for (n = 1; n <= 20; n++) begin
            step(n <= 7 ? pat[n-1][0] : 1'b1);
            if (clean_out) break;
        end
        chk("bounce_lat", n, 9);
        repeat (4) step(1);
        chk("bounce_rise", rise_n, 1);

        repeat (8) step(0);
        chk("pre_rst_low", clean_out, 0);
        clear_counts();
        repeat (5) step(1);
        chk("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_mid", {clean_out, rise_pulse, fall_pulse, busy}, 4'b0000);
        step(1);
        step(1);
        chk("rst_hold_rise", rise_n, 0);
        reset = 1'b0;
        for (n = 1; n <= 20; n++) begin
            step(1);
            if (clean_out) break;
        end
        chk("requal_lat", n, 6);
        repeat (4) step(1);
        chk("requal_rise", rise_n, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
